// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clocks and publishes the saturated count with a valid pulse.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic                 s1_q, s2_q, s3_q;
    logic                 rise;
    logic [0:0]           state_q, state_d;
    logic [GW-1:0]        gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                 ovf_win_q, ovf_win_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 edge_max;

    // Synchronizer and history run independently of en so enabling never sees a stale edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise     = s2_q & ~s3_q;
    assign edge_max = (edge_cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_win_d  = ovf_win_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_win_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d    = ST_MEASURE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_win_d  = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
            // A rise in the closing cycle still belongs to this window
            count_d    = (rise && !edge_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
            ovf_d      = ovf_win_q | (rise & edge_max);
            valid_d    = 1'b1;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_win_d  = 1'b0;
        end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            if (rise) begin
                if (edge_max) begin
                    ovf_win_d = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_win_q  <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_win_q  <= ovf_win_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 4-bit counters, 100-cycle gate)
// share stimulus; expected window results are queued and checked on each valid.
module tb_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sig_in;
    logic [7:0] count8;
    logic       valid8, ovf8, busy8;
    logic [3:0] count4;
    logic       valid4, ovf4, busy4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   half  = 0;
    logic hold_lvl = 1'b0;

    typedef struct {
        bit         chk;
        logic [7:0] c8;
        logic       o8;
        logic [3:0] c4;
        logic       o4;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    exp_t mon_e;

    freq_meter #(.GATE_CYCLES(100), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .count(count8), .valid(valid8), .overflow(ovf8), .busy(busy8)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .count(count4), .valid(valid4), .overflow(ovf4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // half = 0 holds sig_in at hold_lvl; otherwise toggles every half cycles
    initial begin
        sig_in = 1'b0;
        forever begin
            if (half == 0) begin
                @(negedge clk);
                #1 sig_in = hold_lvl;
            end else begin
                repeat (half) @(negedge clk);
                #1 sig_in = ~sig_in;
            end
        end
    end

    always @(negedge clk) begin
        if (valid8 || valid4) begin
            total++;
            vcyc.push_back(cyc);
            if (valid8 !== valid4) begin
                bad++;
                $display("FAIL valid_align cyc=%0d: got valid8=%b valid4=%b, required equal", cyc, valid8, valid4);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cyc=%0d: got valid=1, required no valid", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk && ({count8, ovf8, count4, ovf4} !== {mon_e.c8, mon_e.o8, mon_e.c4, mon_e.o4})) begin
                    bad++;
                    $display("FAIL window_result cyc=%0d: got c8=%0d o8=%b c4=%0d o4=%b, required c8=%0d o8=%b c4=%0d o4=%b",
                             cyc, count8, ovf8, count4, ovf4, mon_e.c8, mon_e.o8, mon_e.c4, mon_e.o4);
                end
            end
        end
    end

    task automatic push_exp(input bit chk, input logic [7:0] c8, input logic o8,
                            input logic [3:0] c4, input logic o4);
        exp_t e;
        e.chk = chk; e.c8 = c8; e.o8 = o8; e.c4 = c4; e.o4 = o4;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge: en is sampled at the next rising edge
    task automatic start_en(output int e);
        en = 1'b1;
        e  = cyc + 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        half  = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) en = 1'b1;
            if (i % 5 == 4) begin
                total++;
                if ({count8, valid8, ovf8, busy8, count4, valid4, ovf4, busy4} !== 16'h0) begin
                    bad++;
                    $display("FAIL reset_hold i=%0d: got c8=%0d v=%b o=%b b=%b c4=%0d, required all 0",
                             i, count8, valid8, ovf8, busy8, count4);
                end
            end
        end
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                total++;
                if ({count8, valid8, ovf8, busy8, count4, valid4, ovf4, busy4} !== 16'h0) begin
                    bad++;
                    $display("FAIL reset_release i=%0d: got c8=%0d v=%b o=%b b=%b c4=%0d, required all 0",
                             i, count8, valid8, ovf8, busy8, count4);
                end
            end
        end
    endtask

    task automatic test_nominal;
        int e;
        half = 5;
        repeat (30) @(negedge clk);
        vcyc.delete();
        push_exp(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) push_exp(1'b1, 8'd10, 1'b0, 4'd10, 1'b0);
        start_en(e);
        wait_cyc(e + 250);
        total++;
        if ((busy8 !== 1'b1) || (busy4 !== 1'b1)) begin
            bad++;
            $display("FAIL nominal_busy: got busy8=%b busy4=%b, required 1", busy8, busy4);
        end
        wait_cyc(e + 401);
        en = 1'b0;
        total++;
        if (vcyc.size() != 4) begin
            bad++;
            $display("FAIL nominal_valid_count: got %0d valids, required 4", vcyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (vcyc[k] != e + 100 * (k + 1)) begin
                    bad++;
                    $display("FAIL nominal_valid_time k=%0d: got cyc %0d, required %0d", k, vcyc[k], e + 100 * (k + 1));
                end
            end
        end
        wait_cyc(e + 403);
        total++;
        if ((busy8 !== 1'b0) || (busy4 !== 1'b0)) begin
            bad++;
            $display("FAIL nominal_busy_off: got busy8=%b busy4=%b, required 0", busy8, busy4);
        end
    endtask

    task automatic test_overflow;
        int e;
        half = 2;
        repeat (20) @(negedge clk);
        vcyc.delete();
        push_exp(1'b1, 8'd25, 1'b0, 4'd15, 1'b1);
        push_exp(1'b1, 8'd25, 1'b0, 4'd15, 1'b1);
        push_exp(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        push_exp(1'b1, 8'd5, 1'b0, 4'd5, 1'b0);
        start_en(e);
        wait_cyc(e + 150);
        total++;
        if ((count4 !== 4'd15) || (ovf4 !== 1'b1)) begin
            bad++;
            $display("FAIL overflow_hold: got c4=%0d o4=%b, required 15 1", count4, ovf4);
        end
        wait_cyc(e + 201);
        half = 10;
        wait_cyc(e + 401);
        en = 1'b0;
        total++;
        if (vcyc.size() != 4) begin
            bad++;
            $display("FAIL overflow_valid_count: got %0d valids, required 4", vcyc.size());
        end
    endtask

    task automatic test_abort;
        int e, e2;
        half = 5;
        repeat (30) @(negedge clk);
        vcyc.delete();
        start_en(e);
        wait_cyc(e + 59);
        total++;
        if ((busy8 !== 1'b1) || (busy4 !== 1'b1)) begin
            bad++;
            $display("FAIL abort_busy_before: got busy8=%b busy4=%b, required 1", busy8, busy4);
        end
        en = 1'b0;
        wait_cyc(e + 60);
        total++;
        if ({busy8, busy4, count8, ovf8, count4, ovf4} !== {1'b0, 1'b0, 8'd5, 1'b0, 4'd5, 1'b0}) begin
            bad++;
            $display("FAIL abort_state: got b8=%b b4=%b c8=%0d o8=%b c4=%0d o4=%b, required 0 0 5 0 5 0",
                     busy8, busy4, count8, ovf8, count4, ovf4);
        end
        wait_cyc(e + 120);
        total++;
        if (vcyc.size() != 0) begin
            bad++;
            $display("FAIL abort_no_valid: got %0d valids, required 0", vcyc.size());
        end
        push_exp(1'b1, 8'd10, 1'b0, 4'd10, 1'b0);
        start_en(e2);
        wait_cyc(e2 + 101);
        en = 1'b0;
        total++;
        if ((vcyc.size() != 1) || (vcyc[0] != e2 + 100)) begin
            bad++;
            $display("FAIL abort_reenable: got %0d valids first at %0d, required 1 at %0d",
                     vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, e2 + 100);
        end
    endtask

    task automatic test_midreset;
        int e;
        vcyc.delete();
        repeat (5) @(negedge clk);
        start_en(e);
        wait_cyc(e + 50);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({count8, valid8, ovf8, busy8, count4, valid4, ovf4, busy4} !== 16'h0) begin
            bad++;
            $display("FAIL midreset_clear: got c8=%0d v=%b o=%b b=%b c4=%0d, required all 0",
                     count8, valid8, ovf8, busy8, count4);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(e + 110);
        total++;
        if (vcyc.size() != 0) begin
            bad++;
            $display("FAIL midreset_no_valid: got %0d valids, required 0", vcyc.size());
        end
    endtask

    task automatic test_boundary;
        int e;
        hold_lvl = 1'b0;
        half     = 0;
        repeat (30) @(negedge clk);
        vcyc.delete();
        push_exp(1'b1, 8'd1, 1'b0, 4'd1, 1'b0);
        push_exp(1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
        start_en(e);
        // sig_in rises before edge e+98, so rise is high in the gate_cnt==99 cycle
        wait_cyc(e + 97);
        hold_lvl = 1'b1;
        wait_cyc(e + 299);
        en = 1'b0;
        wait_cyc(e + 300);
        total++;
        if ((valid8 !== 1'b0) || (valid4 !== 1'b0)) begin
            bad++;
            $display("FAIL boundary_abort_valid: got valid8=%b valid4=%b, required 0", valid8, valid4);
        end
        wait_cyc(e + 302);
        total++;
        if ((vcyc.size() != 2) || (vcyc[0] != e + 100) || (vcyc[1] != e + 200)) begin
            bad++;
            $display("FAIL boundary_valid_times: got %0d valids, required 2 at %0d,%0d", vcyc.size(), e + 100, e + 200);
        end
        total++;
        if ({busy8, busy4, count8, count4} !== 14'h0) begin
            bad++;
            $display("FAIL boundary_after: got b8=%b b4=%b c8=%0d c4=%0d, required 0 0 0 0", busy8, busy4, count8, count4);
        end
        hold_lvl = 1'b0;
    endtask

    task automatic test_idle_high;
        int e;
        hold_lvl = 1'b1;
        repeat (50) @(negedge clk);
        vcyc.delete();
        push_exp(1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
        start_en(e);
        wait_cyc(e + 101);
        en = 1'b0;
        total++;
        if ((vcyc.size() != 1) || (vcyc[0] != e + 100)) begin
            bad++;
            $display("FAIL idle_high_valid: got %0d valids, required 1 at %0d", vcyc.size(), e + 100);
        end
        hold_lvl = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_overflow();
        test_abort();
        test_midreset();
        test_boundary();
        test_idle_high();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency meter: counts rising edges of an asynchronous input signal over a fixed window of `GATE_CYCLES` system clocks, then publishes the count with a one-cycle valid pulse. It is the measuring counterpart of the clock divider. The divider produces a slow clock from `clk`; this block recovers the rate of a slow signal, such as a divider output or an external pulse, in units of `clk`. It runs continuously while enabled and feeds the display/readout logic.

## Interface
- `GATE_CYCLES`, default 1000: window length in `clk` cycles; must be ≥ 2.
- `CNT_WIDTH`, default 16: width of the edge counter and of the result.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  synchronous enable; low aborts the current window and idles the block.
- `sig_in`  input  1  signal under measurement, asynchronous to `clk`.
- `count`  output  CNT_WIDTH  rising edges counted in the last completed window; holds between windows.
- `valid`  output  1  one-cycle pulse when `count`/`overflow` update.
- `overflow`  output  1  last completed window saturated the counter; updated together with `count`.
- `busy`  output  1  high while a window is in progress (state MEASURE).

## Operation
- **Input synchronizer**
  - `sig_in` passes through a 2-flop synchronizer (`s1`, `s2`), then a history flop `s3`.
  - `rise = s2 & ~s3`.
  - The synchronizer and history flops run regardless of `en`, so enabling while `sig_in` is high never produces a false edge.
- **State machine** (two states, IDLE and MEASURE):
  - IDLE: `gate_cnt = 0`, `edge_cnt = 0`. Goes to MEASURE on the first cycle `en` = 1.
  - MEASURE: `gate_cnt` increments each cycle from 0 to `GATE_CYCLES-1`. `edge_cnt` increments on `rise`.
  - At window end (`gate_cnt == GATE_CYCLES-1`):
    - `count <= sat(edge_cnt + rise)`; a `rise` in the last cycle belongs to the closing window.
    - `overflow <=` 1 if the saturated value would have been exceeded, else 0.
    - `valid <= 1`.
    - `gate_cnt <= 0` and `edge_cnt <= 0`; the next window starts immediately with no dead cycle.
  - `en` = 0 in any state: go to IDLE and clear `gate_cnt` and `edge_cnt`. The partial window is discarded: no `valid`, and `count`/`overflow` keep their last values.
- **Saturation**
  - `edge_cnt` stops at 2^CNT_WIDTH − 1 and never wraps.
  - `overflow` is set when a `rise` arrives while `edge_cnt` is already at maximum, or at the window-end update when `edge_cnt` is at maximum and `rise` = 1.
- **Simultaneous events**
  - `en` falling in the window-end cycle: the abort wins; no `valid` and no update.
  - `rise` in the window-end cycle: counted in the closing window; the new window starts at 0.
- **Reset**
  - Asserting `rst_n` low mid-window immediately clears all state.
  - No `valid` is produced for the interrupted window.

## Timing
- Reset values:
  - `count` = 0, `valid` = 0, `overflow` = 0, `busy` = 0.
  - `gate_cnt` = 0, `edge_cnt` = 0; synchronizer and history flops = 0; state = IDLE.
- `sig_in` rising before `clk` edge N (meeting setup) → `rise` high during the cycle after edge N+1 → `edge_cnt` updates at edge N+2.
- `en` sampled high at edge E:
  - `busy` = 1 from E.
  - The window covers the cycles between edges E and E+GATE_CYCLES.
  - `count`/`overflow` update and `valid` rises at edge E+GATE_CYCLES; `valid` falls one cycle later.
- In steady state, `valid` pulses exactly every `GATE_CYCLES` cycles.
- `busy` stays 1 across window boundaries and falls the cycle after `en` is sampled low.
- Measurable rate: `sig_in` high and low phases must each be ≥ 2 `clk` periods. Narrower pulses may be missed; this is not flagged.

## Test plan
- **Reset:** hold `rst_n` = 0 with `sig_in` toggling → all outputs 0 and no `valid`. Deassert with `en` = 0 → outputs stay 0.
- **Nominal:** `GATE_CYCLES` = 100, `CNT_WIDTH` = 8, `sig_in` period 10 clk (5 high / 5 low), `en` = 1.
  - `valid` pulses every 100 cycles.
  - From the second window on, `count` = 10 and `overflow` = 0.
- **Overflow:** `CNT_WIDTH` = 4, `GATE_CYCLES` = 100, `sig_in` period 4 clk → `count` = 15, `overflow` = 1. Then slow to period 20 → next full window gives `count` = 5, `overflow` = 0.
- **Abort:** `en` drops at cycle 60 of a window → no `valid`, `busy` falls next cycle, `count` keeps its old value. Re-enable → first `valid` arrives exactly 100 cycles after `en` is sampled high.
- **Boundary edge:** place a `sig_in` edge so `rise` lands in the window-end cycle → it is counted in that window's `count` and not in the next one. `en` low in the window-end cycle → no `valid`.
- **Idle-high enable:** `sig_in` held high for 50 cycles, then `en` raised → zero edges counted in the first window.
